// File: rtl/edge_bbox_stat.sv
// Per-frame edge statistics behind the Sobel stage: counts edge pixels (sobel == 0),
// tracks their bounding box, and publishes the results with a one-cycle stat_done pulse.
module edge_bbox_stat #(
  parameter int IMG_WIDTH    = 640,
  parameter int IMG_HEIGHT   = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int CNT_W        = 19,
  parameter int MIN_EDGE_CNT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sobel,
  input  logic             sobel_valid,
  input  logic             sobel_hsync,
  input  logic             sobel_vsync,
  output logic [X_W-1:0]   bbox_x_min,
  output logic [X_W-1:0]   bbox_x_max,
  output logic [Y_W-1:0]   bbox_y_min,
  output logic [Y_W-1:0]   bbox_y_max,
  output logic [CNT_W-1:0] edge_count,
  output logic             bbox_found,
  output logic             frame_err,
  output logic             stat_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_EDGE_CNT);

  state_t           state;
  logic             hsync_d, vsync_d;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             x_full, y_full, line_px, rise_pend;
  logic [X_W-1:0]   acc_xmin, acc_xmax;
  logic [Y_W-1:0]   acc_ymin, acc_ymax;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_err;

  logic accept, edge_px, vsync_rise, hsync_fall, y_step, x_ovf, y_ovf;

  assign accept     = sobel_valid & sobel_hsync & sobel_vsync;
  assign edge_px    = accept & ~sobel;
  assign vsync_rise = sobel_vsync & ~vsync_d;
  assign hsync_fall = hsync_d & ~sobel_hsync;
  assign y_step     = hsync_fall & sobel_vsync & line_px;
  // The last column/line is legal once; only a second hit at the held coordinate overflows.
  assign x_ovf      = accept & (x == X_LAST) & x_full;
  assign y_ovf      = y_step & (y == Y_LAST) & y_full & ~vsync_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_d <= 1'b0;
      // NOTE: vsync_d resets high so a frame already in progress at reset release
      // does not look like a fresh vsync rise.
      vsync_d <= 1'b1;
      x       <= '0;
      x_full  <= 1'b0;
      y       <= '0;
      y_full  <= 1'b0;
      line_px <= 1'b0;
    end else begin
      hsync_d <= sobel_hsync;
      vsync_d <= sobel_vsync;

      if (!sobel_hsync) begin
        x      <= '0;
        x_full <= 1'b0;
      end else if (accept) begin
        if (x == X_LAST) x_full <= 1'b1;
        else             x      <= x + 1'b1;
      end

      if (hsync_fall)  line_px <= 1'b0;
      else if (accept) line_px <= 1'b1;

      if (vsync_rise) begin
        y      <= '0;
        y_full <= 1'b0;
      end else if (y_step) begin
        if (y == Y_LAST) y_full <= 1'b1;
        else             y      <= y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rise_pend  <= 1'b0;
      acc_xmin   <= '0;
      acc_xmax   <= '0;
      acc_ymin   <= '0;
      acc_ymax   <= '0;
      acc_cnt    <= '0;
      acc_err    <= 1'b0;
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
      edge_count <= '0;
      bbox_found <= 1'b0;
      frame_err  <= 1'b0;
      stat_done  <= 1'b0;
    end else begin
      // NOTE: default-low here turns the DONE assignment into a single-cycle pulse.
      stat_done <= 1'b0;

      // A rise seen while still closing the previous frame is remembered for IDLE.
      if (vsync_rise && state != IDLE) rise_pend <= 1'b1;

      case (state)
        IDLE: begin
          rise_pend <= 1'b0;
          if (vsync_rise || (rise_pend && vsync_d)) begin
            state    <= ACTIVE;
            acc_xmin <= X_LAST;
            acc_xmax <= '0;
            acc_ymin <= Y_LAST;
            acc_ymax <= '0;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
          end
        end

        ACTIVE: begin
          if (!vsync_d) begin
            state <= DONE;
          end else begin
            if (edge_px) begin
              if (x < acc_xmin) acc_xmin <= x;
              if (x > acc_xmax) acc_xmax <= x;
              if (y < acc_ymin) acc_ymin <= y;
              if (y > acc_ymax) acc_ymax <= y;
              if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
            end
            if (x_ovf || y_ovf) acc_err <= 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          stat_done  <= 1'b1;
          edge_count <= acc_cnt;
          frame_err  <= acc_err;
          if (acc_cnt >= CNT_MIN) begin
            bbox_found <= 1'b1;
            bbox_x_min <= acc_xmin;
            bbox_x_max <= acc_xmax;
            bbox_y_min <= acc_ymin;
            bbox_y_max <= acc_ymax;
          end else begin
            bbox_found <= 1'b0;
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_bbox_stat.sv
// Bench for edge_bbox_stat on an 8x6 image: directed frame table, mid-frame reset and
// randomized frames against a list-based reference model. DUT a: MIN=1, DUT b: MIN=4, 5-bit count.
module tb_edge_bbox_stat;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    int xmin; int xmax; int ymin; int ymax; int cnt; int found; int err;
  } res_t;

  typedef struct {
    int   cyc;
    int   b_done;
    res_t a;
    res_t b;
  } rec_t;

  // Edges are encoded as line*16 + pixel_index, -1 for unused slots.
  typedef struct {
    int   n_lines; int long_line; int long_len;
    int   e0; int e1; int e2; int e3;
    int   all_edge; int tail; int vblank;
    res_t a;
  } vec_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic sobel = 1'b1, sobel_valid = 1'b0, sobel_hsync = 1'b0, sobel_vsync = 1'b0;
  logic [2:0] xmin_a, xmax_a, ymin_a, ymax_a, xmin_b, xmax_b, ymin_b, ymax_b;
  logic [5:0] cnt_a;
  logic [4:0] cnt_b;
  logic found_a, err_a, done_a, found_b, err_b, done_b;

  edge_bbox_stat #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(3), .Y_W(3), .CNT_W(6), .MIN_EDGE_CNT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .sobel(sobel), .sobel_valid(sobel_valid),
    .sobel_hsync(sobel_hsync), .sobel_vsync(sobel_vsync),
    .bbox_x_min(xmin_a), .bbox_x_max(xmax_a), .bbox_y_min(ymin_a), .bbox_y_max(ymax_a),
    .edge_count(cnt_a), .bbox_found(found_a), .frame_err(err_a), .stat_done(done_a));

  edge_bbox_stat #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(3), .Y_W(3), .CNT_W(5), .MIN_EDGE_CNT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .sobel(sobel), .sobel_valid(sobel_valid),
    .sobel_hsync(sobel_hsync), .sobel_vsync(sobel_vsync),
    .bbox_x_min(xmin_b), .bbox_x_max(xmax_b), .bbox_y_min(ymin_b), .bbox_y_max(ymax_b),
    .edge_count(cnt_b), .bbox_found(found_b), .frame_err(err_b), .stat_done(done_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  rec_t got_q[$];
  rec_t exp_q[$];
  rec_t mon_r;

  bit pix [16][16];
  int llen[16];
  int nlines;
  vec_t tbl[7];

  always @(negedge clk) begin
    if (done_a || done_b) begin
      mon_r.cyc    = cyc;
      mon_r.b_done = int'(done_b);
      mon_r.a = '{int'(xmin_a), int'(xmax_a), int'(ymin_a), int'(ymax_a),
                  int'(cnt_a), int'(found_a), int'(err_a)};
      mon_r.b = '{int'(xmin_b), int'(xmax_b), int'(ymin_b), int'(ymax_b),
                  int'(cnt_b), int'(found_b), int'(err_b)};
      got_q.push_back(mon_r);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmp_res(input string tag, input res_t g, input res_t e);
    check({tag, "_xmin"},  g.xmin,  e.xmin);
    check({tag, "_xmax"},  g.xmax,  e.xmax);
    check({tag, "_ymin"},  g.ymin,  e.ymin);
    check({tag, "_ymax"},  g.ymax,  e.ymax);
    check({tag, "_count"}, g.cnt,   e.cnt);
    check({tag, "_found"}, g.found, e.found);
    check({tag, "_err"},   g.err,   e.err);
  endtask

  task automatic check_queue();
    rec_t g, e;
    check("done_pulses", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check("done_cycle", g.cyc, e.cyc);
      check("done_b_aligned", g.b_done, e.b_done);
      cmp_res("a", g.a, e.a);
      cmp_res("b", g.b, e.b);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Reference: collect edge coordinates (clamped to the last column/line) and reduce.
  function automatic res_t model(input int min_e, input int cnt_max);
    res_t r;
    int   xs[$], ys[$];
    int   xx, yy;
    r = '0;
    for (int l = 0; l < nlines; l++)
      for (int p = 0; p < llen[l]; p++) begin
        if (l >= H || p >= W) r.err = 1;
        if (!pix[l][p]) begin
          xs.push_back((p < W) ? p : W - 1);
          ys.push_back((l < H) ? l : H - 1);
        end
      end
    r.cnt   = (xs.size() > cnt_max) ? cnt_max : xs.size();
    r.found = (r.cnt >= min_e) ? 1 : 0;
    if (r.found != 0) begin
      r.xmin = W - 1; r.ymin = H - 1;
      foreach (xs[i]) begin
        xx = xs[i]; yy = ys[i];
        if (xx < r.xmin) r.xmin = xx;
        if (xx > r.xmax) r.xmax = xx;
        if (yy < r.ymin) r.ymin = yy;
        if (yy > r.ymax) r.ymax = yy;
      end
    end
    return r;
  endfunction

  function automatic res_t derive_b(input res_t a);
    res_t b = a;
    b.cnt   = (a.cnt > 31) ? 31 : a.cnt;
    b.found = (b.cnt >= 4) ? 1 : 0;
    if (b.found == 0) begin
      b.xmin = 0; b.xmax = 0; b.ymin = 0; b.ymax = 0;
    end
    return b;
  endfunction

  task automatic set_edge(input int e);
    if (e >= 0) pix[e / 16][e % 16] = 1'b0;
  endtask

  task automatic build_vec(input vec_t v);
    nlines = v.n_lines;
    for (int l = 0; l < 16; l++) begin
      llen[l] = (l == v.long_line) ? v.long_len : W;
      for (int p = 0; p < 16; p++) pix[l][p] = (v.all_edge != 0) ? 1'b0 : 1'b1;
    end
    set_edge(v.e0); set_edge(v.e1); set_edge(v.e2); set_edge(v.e3);
  endtask

  task automatic drive_line(input int l, input bit gaps);
    sobel_hsync = 1'b1;
    for (int p = 0; p < llen[l]; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sobel_valid = 1'b0;
        tick();
      end
      sobel_valid = 1'b1;
      sobel       = pix[l][p];
      tick();
    end
    sobel_valid = 1'b0;
    sobel       = 1'b1;
    sobel_hsync = 1'b0;
    tick();
    tick();
  endtask

  // stat_done is due 3 edges after vsync is dropped at a falling edge.
  task automatic drive_frame(input int vblank, input bit tail, input bit gaps, input rec_t exp);
    sobel_vsync = 1'b1;
    repeat (4) tick();
    for (int l = 0; l < nlines; l++) drive_line(l, gaps);
    sobel_vsync = 1'b0;
    if (tail) begin
      sobel_valid = 1'b1;
      sobel_hsync = 1'b1;
      sobel       = 1'b0;
    end
    exp.cyc = cyc + 3;
    exp_q.push_back(exp);
    tick();
    sobel_valid = 1'b0;
    sobel_hsync = 1'b0;
    sobel       = 1'b1;
    repeat (vblank - 1) tick();
  endtask

  task automatic run_vec(input int i);
    rec_t e;
    build_vec(tbl[i]);
    e.cyc = 0;
    e.b_done = 1;
    e.a = tbl[i].a;
    e.b = derive_b(tbl[i].a);
    drive_frame(tbl[i].vblank, tbl[i].tail != 0, 1'b0, e);
    if (tbl[i].vblank > 1) begin
      repeat (8) tick();
      check_queue();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    rec_t e;
    int   vb;

    //            lines long len  e0  e1  e2  e3 all tail vb   xmin xmax ymin ymax cnt found err
    tbl[0] = '{6, -1, 0,  35, -1, -1, -1, 0, 0, 4, '{3, 3, 2, 2, 1, 1, 0}};
    tbl[1] = '{6, -1, 0,  17, 70, 82, -1, 0, 1, 4, '{1, 6, 1, 5, 3, 1, 0}};
    tbl[2] = '{6, -1, 0,   0, 87, 52, 34, 0, 0, 3, '{0, 7, 0, 5, 4, 1, 0}};
    tbl[3] = '{6,  1, 9,  24, 50, -1, -1, 0, 0, 3, '{2, 7, 1, 3, 2, 1, 1}};
    tbl[4] = '{7, -1, 0,  97, -1, -1, -1, 0, 0, 3, '{1, 1, 5, 5, 1, 1, 1}};
    tbl[5] = '{6, -1, 0,  -1, -1, -1, -1, 1, 0, 1, '{0, 7, 0, 5, 48, 1, 0}};
    tbl[6] = '{6, -1, 0,  -1, -1, -1, -1, 0, 0, 4, '{0, 0, 0, 0, 0, 0, 0}};

    repeat (3) tick();
    check("rst_count",  int'(cnt_a),   0);
    check("rst_found",  int'(found_a), 0);
    check("rst_done",   int'(done_a),  0);
    check("rst_bbox",   int'({xmin_a, xmax_a, ymin_a, ymax_a}), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Mid-frame reset with vsync held high: outputs clear at once, the frame is dropped.
    run_vec(0);
    build_vec(tbl[2]);
    sobel_vsync = 1'b1;
    repeat (4) tick();
    drive_line(0, 1'b0);
    drive_line(1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_xmin",  int'(xmin_a),  0);
    check("midrst_ymax",  int'(ymax_a),  0);
    check("midrst_count", int'(cnt_a),   0);
    check("midrst_found", int'(found_a), 0);
    check("midrst_err",   int'(err_a),   0);
    check("midrst_b_cnt", int'(cnt_b),   0);
    tick();
    reset_n = 1'b1;
    drive_line(2, 1'b0);
    drive_line(3, 1'b0);
    sobel_vsync = 1'b0;
    repeat (10) tick();
    check_queue();
    run_vec(1);

    // Randomized frames, including overlong lines/frames and 1-cycle vblanks.
    for (int f = 0; f < 25; f++) begin
      nlines = ($urandom_range(0, 5) == 0) ? 7 : $urandom_range(1, 6);
      vb     = $urandom_range(0, 7);
      for (int l = 0; l < 16; l++) begin
        llen[l] = ($urandom_range(0, 5) == 0) ? 9 : $urandom_range(1, 8);
        for (int p = 0; p < 16; p++) pix[l][p] = ($urandom_range(0, 7) < vb) ? 1'b0 : 1'b1;
      end
      e.cyc    = 0;
      e.b_done = 1;
      e.a      = model(1, 63);
      e.b      = model(4, 31);
      vb = (f == 24) ? 4 : $urandom_range(1, 3);
      drive_frame(vb, $urandom_range(0, 1) == 1, 1'b1, e);
      if (vb > 1) begin
        repeat (6) tick();
        check_queue();
      end
    end
    repeat (6) tick();
    check_queue();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
